// File: rtl/tetris_update_ref.sv
// Move codes shared with the movement decoder, and the registered next-position
// calculator for the falling piece's reference cell on a 10x20 board.
package tetris_pkg;
  typedef enum logic [2:0] {
    MOVE_LEFT   = 3'd0,
    MOVE_RIGHT  = 3'd1,
    MOVE_DOWN   = 3'd2,
    MOVE_ROTATE = 3'd3,
    MOVE_NONE   = 3'd4
  } move_t;
endpackage

module tetris_update_ref
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  move_t       movement,
  input  logic [3:0]  row_i,
  input  logic [4:0]  col_i,
  output logic [3:0]  row_o,
  output logic [4:0]  col_o
);

  localparam logic [3:0] ROW_MAX = 4'd9;
  localparam logic [4:0] COL_MAX = 5'd19;

  logic [3:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [3:0] row_sat;
  logic [4:0] col_sat;

  function automatic logic [3:0] sat_row(input logic [3:0] r);
    return (r > ROW_MAX) ? ROW_MAX : r;
  endfunction

  function automatic logic [4:0] sat_col(input logic [4:0] c);
    return (c > COL_MAX) ? COL_MAX : c;
  endfunction

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    row_sat = sat_row(row_i);
    col_sat = sat_col(col_i);
    if (en) begin
      row_d = row_sat;
      col_d = col_sat;
      // Rotate and the unused codes 5..7 leave the anchor where it is.
      case (movement)
        MOVE_LEFT:  row_d = (row_sat != 4'd0)   ? row_sat - 4'd1 : 4'd0;
        MOVE_RIGHT: row_d = (row_sat < ROW_MAX) ? row_sat + 4'd1 : ROW_MAX;
        MOVE_DOWN:  col_d = (col_sat < COL_MAX) ? col_sat + 5'd1 : COL_MAX;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= 4'd0;
      col_q <= 5'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: tb/tb_tetris_update_ref.sv
// Bench for tetris_update_ref: directed plan steps, random traffic and a full
// input sweep, all checked against an arithmetic model of the move rules.
module tb_tetris_update_ref;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  move_t      movement = MOVE_NONE;
  logic [3:0] row_i = '0;
  logic [4:0] col_i = '0;
  logic [3:0] row_o;
  logic [4:0] col_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_row = 0;
  int exp_col = 0;

  tetris_update_ref dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .movement (movement),
    .row_i    (row_i),
    .col_i    (col_i),
    .row_o    (row_o),
    .col_o    (col_o)
  );

  always #5 clk = ~clk;

  function automatic void model(input bit e, input int mv, input int ri, input int ci);
    int r;
    int c;
    if (!e) return;
    r = (ri > 9)  ? 9  : ri;
    c = (ci > 19) ? 19 : ci;
    if (mv == 0) r = (r > 0)  ? r - 1 : 0;
    if (mv == 1) r = (r < 9)  ? r + 1 : 9;
    if (mv == 2) c = (c < 19) ? c + 1 : 19;
    exp_row = r;
    exp_col = c;
  endfunction

  task automatic check(input string tag);
    logic [3:0] er;
    logic [4:0] ec;
    er = exp_row[3:0];
    ec = exp_col[4:0];
    n_cmp++;
    assert (row_o === er) else begin
      n_fail++;
      $error("FAIL %s row_o: got %0d expected %0d", tag, row_o, er);
    end
    n_cmp++;
    assert (col_o === ec) else begin
      n_fail++;
      $error("FAIL %s col_o: got %0d expected %0d", tag, col_o, ec);
    end
  endtask

  task automatic step(input bit rs, input bit e, input int mv, input int ri,
                      input int ci, input string tag);
    logic [2:0] m3;
    @(negedge clk);
    m3       = mv[2:0];
    rst      = rs;
    en       = e;
    movement = move_t'(m3);
    row_i    = ri[3:0];
    col_i    = ci[4:0];
    @(posedge clk);
    #1;
    if (rs) begin
      exp_row = 0;
      exp_col = 0;
    end else begin
      model(e, mv, ri, ci);
    end
    check(tag);
  endtask

  initial begin
    // Reset held with a live request present
    step(1, 1, 4, 5, 7, "reset0");
    step(1, 1, 4, 5, 7, "reset1");
    step(0, 1, 4, 5, 7, "reset_release");

    step(0, 1, 0, 0, 11, "left_at_0");
    step(0, 1, 1, 9, 12, "right_at_9");
    step(0, 1, 0, 4, 13, "left_4");
    step(0, 1, 1, 4, 14, "right_4");

    step(0, 1, 2, 6, 18, "down_18");
    step(0, 1, 2, 6, 19, "down_19");
    step(0, 1, 2, 6, 0,  "down_0");

    step(0, 1, 4, 15, 25, "sat_none");
    step(0, 1, 1, 12, 3,  "sat_right");
    step(0, 1, 0, 12, 3,  "sat_left");
    step(0, 1, 2, 15, 31, "sat_down");

    step(0, 1, 3, 3, 6, "rotate");
    step(0, 1, 5, 3, 6, "code5");
    step(0, 1, 6, 3, 6, "code6");
    step(0, 1, 7, 3, 6, "code7");

    step(0, 1, 4, 2, 2, "en_load");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 10, "en_hold");
    step(0, 1, 1, 7, 10, "en_resume");

    step(1, 0, 1, 3, 3, "reset_no_en");
    step(0, 1, 2, 8, 8, "after_reset");
    step(1, 1, 1, 3, 3, "reset_over_en");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 31)), "random");
    end

    for (int mv = 0; mv < 8; mv++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 32; c++)
          step(0, 1, mv, r, c, "sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
